// File: rtl/noc_pkg.sv
// Flit layout and tracker state shared by the NoC endpoints (sink and traffic generator).
package noc_pkg;
  localparam int SEQ_W     = 11;
  localparam int NODE_W    = 2;
  localparam int FLIT_W    = 16;
  localparam int VALID_BIT = 0;
  localparam int DEST_LSB  = 1;
  localparam int SRC_LSB   = 3;
  localparam int SEQ_LSB   = 5;

  typedef struct packed {
    logic [SEQ_W-1:0]  seq;
    logic [NODE_W-1:0] src;
    logic [NODE_W-1:0] dest;
    logic              valid;
  } flit_t;

  typedef enum logic {UNSYNC, SYNCED} trk_state_e;
endpackage

// File: rtl/noc_seq_tracker.sv
// Per-source sequence checker: syncs on the first accepted flit, then expects seq to advance by STRIDE.
module noc_seq_tracker
  import noc_pkg::*;
#(
  parameter logic [SEQ_W-1:0] STRIDE = 11'd3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             hit,
  input  logic [SEQ_W-1:0] seq,
  output logic             err
);
  trk_state_e       state, state_nxt;
  logic [SEQ_W-1:0] expected, expected_nxt;

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= UNSYNC;
      expected <= '0;
    end else begin
      state    <= state_nxt;
      expected <= expected_nxt;
    end
  end

  // Match and mismatch both land on seq+STRIDE, so the resync path is free.
  always_comb begin
    state_nxt    = state;
    expected_nxt = expected;
    err          = 1'b0;
    if (hit) begin
      err          = (state == SYNCED) && (seq != expected);
      state_nxt    = SYNCED;
      expected_nxt = seq + STRIDE;
    end
  end
endmodule

// File: rtl/noc_rx_sink.sv
// NoC receive endpoint: decodes flits, flags misroutes and sequence gaps, keeps saturating stats.
module noc_rx_sink
  import noc_pkg::*;
#(
  parameter logic [NODE_W-1:0] ID        = 2'd0,
  parameter int                NUM_NODES = 4,
  parameter int                CNT_W     = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [FLIT_W-1:0]    dataIn,
  input  logic                 clear_stats,
  output logic                 flit_valid,
  output logic [NODE_W-1:0]    flit_src,
  output logic [SEQ_W-1:0]     flit_seq,
  output logic                 seq_error,
  output logic [CNT_W-1:0]     rx_count,
  output logic [CNT_W-1:0]     seq_err_count,
  output logic [CNT_W-1:0]     misroute_count
);
  localparam logic [SEQ_W-1:0] STRIDE = SEQ_W'(NUM_NODES - 1);

  flit_t                f;
  logic                 misroute, accept, seq_err_now;
  logic [NUM_NODES-1:0] hit, trk_err;

  assign f           = flit_t'(dataIn);
  assign misroute    = f.valid && ((f.dest != ID) || (f.src == ID));
  assign accept      = f.valid && !misroute;
  assign seq_err_now = |trk_err;

  // accept already excludes src==ID, so that tracker never sees a hit.
  for (genvar i = 0; i < NUM_NODES; i++) begin : g_trk
    assign hit[i] = accept && (f.src == NODE_W'(i));
    noc_seq_tracker #(.STRIDE(STRIDE)) u_trk (
      .clk   (clk),
      .reset (reset),
      .hit   (hit[i]),
      .seq   (f.seq),
      .err   (trk_err[i])
    );
  end

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (&c) ? c : c + CNT_W'(1);
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      flit_valid     <= 1'b0;
      seq_error      <= 1'b0;
      flit_src       <= '0;
      flit_seq       <= '0;
      rx_count       <= '0;
      seq_err_count  <= '0;
      misroute_count <= '0;
    end else begin
      flit_valid <= accept;
      seq_error  <= seq_err_now;
      if (accept) begin
        flit_src <= f.src;
        flit_seq <= f.seq;
      end
      // Clear beats a coinciding increment; pulses above are unaffected.
      if (clear_stats) begin
        rx_count       <= '0;
        seq_err_count  <= '0;
        misroute_count <= '0;
      end else begin
        if (accept)      rx_count       <= sat_inc(rx_count);
        if (seq_err_now) seq_err_count  <= sat_inc(seq_err_count);
        if (misroute)    misroute_count <= sat_inc(misroute_count);
      end
    end
  end
endmodule

// File: doc/noc_rx_sink.md
# noc_rx_sink

Receive-side endpoint for one NoC node: consumes the 16-bit flits delivered on a node's NoC output port and decodes the packet format {seq[10:0], src[1:0], dest[1:0], valid}. It tracks a per-source sequence number and counts delivered, misrouted and out-of-sequence flits, so NoC benches can self-check delivery. It is instantiated once per node, beside the traffic generator that drives the same node's input port.

## Interface
- ID, 0: this node's 2-bit address.
- NUM_NODES, 4: node count; per-source sequence stride is NUM_NODES-1.
- CNT_W, 16: statistics counter width.

- clk  in  1  clock; all logic on the rising edge.
- reset  in  1  synchronous, active-high reset.
- dataIn  in  16  flit from the NoC output port; bit 0 = valid.
- clear_stats  in  1  synchronous clear of the counters only.
- flit_valid  out  1  one-cycle pulse per accepted, correctly routed flit.
- flit_src  out  2  source of the last accepted flit.
- flit_seq  out  11  sequence number of the last accepted flit.
- seq_error  out  1  one-cycle pulse when an accepted flit fails the sequence check.
- rx_count  out  CNT_W  correctly routed flits received (saturating).
- seq_err_count  out  CNT_W  sequence errors (saturating).
- misroute_count  out  CNT_W  flits with dest≠ID or src==ID (saturating).

## Operation
- A flit is present when dataIn[0]==1. The NoC presents each flit for exactly one cycle, so the sink samples every cycle.
- Field decode: seq=dataIn[15:5], src=dataIn[4:3], dest=dataIn[2:1].
- Misroute: dest≠ID or src==ID. Effect:
  - misroute_count increments.
  - No flit_valid, no sequence check, tracker state unchanged.
- Accept (otherwise):
  - flit_valid=1, flit_src/flit_seq loaded.
  - rx_count increments.
  - The per-source tracker is consulted.
- Per-source tracker: 2 states, UNSYNC and SYNCED, plus an 11-bit expected value.
  - UNSYNC + accept: no error; expected = seq + (NUM_NODES-1) mod 2048; go to SYNCED.
  - SYNCED + accept with seq==expected: no error; expected += NUM_NODES-1 mod 2048.
  - SYNCED + accept with seq≠expected: seq_error=1, seq_err_count increments. Resync: expected = seq + (NUM_NODES-1) mod 2048. Stay SYNCED.
- The tracker for src==ID is never used.
- Arithmetic:
  - Sequence addition is 11-bit modulo; wrap is legal (2046 → 1 for stride 3).
  - Counters saturate at all-ones and never wrap.
- clear_stats: zeroes the three counters only. Trackers keep their state.
- clear_stats with a simultaneous flit: the clear wins, so the counter reads 0, not 1. Pulses and flit_src/flit_seq still update normally.

## Timing
- Single register stage: a flit sampled at edge N drives all outputs and counters from edge N onward. Latency is 1 cycle.
- flit_valid and seq_error are high for exactly one cycle per flit. Back-to-back flits produce back-to-back pulses, with no dead cycle required.
- Reset values:
  - All outputs 0 (flit_valid, seq_error, flit_src, flit_seq, all counters).
  - All trackers UNSYNC, expected=0.
- Reset mid-stream: the next flit from each source is treated as the first (no error).
- Reset has priority over clear_stats and dataIn.
- No back-pressure: the sink accepts every cycle and never stalls the NoC.

## Structure
- Shared package noc_pkg holds:
  - Flit field constants: SEQ_W=11, NODE_W=2, and bit positions for seq, src, dest and valid.
  - A packed flit typedef.
  - Tracker state enum {UNSYNC, SYNCED}.
  - The traffic generator uses the same package.
- Sub-module noc_seq_tracker: one per source, generated NUM_NODES times.
  - Inputs: hit, seq.
  - Outputs: err.
  - Holds the state and expected registers.
- The top level does decode, misroute check, counters and output registers.

## Test plan
All scenarios use ID=1, NUM_NODES=4.
- Reset then idle (dataIn=16'h0000 for 10 cycles): all outputs 0, no pulses.
- In-order stream from src0 (16'h0003, 16'h0063, 16'h00C3, i.e. seq 0,3,6):
  - three flit_valid pulses, each 1 cycle after its flit;
  - rx_count=3, seq_err_count=0, last flit_seq=6.
- Gap from src0 (16'h0003, 16'h0063, then 16'h0123, i.e. seq 9 where 6 is expected):
  - seq_error pulses on the third flit, seq_err_count=1;
  - a following seq 12 (16'h0183) gives no error (resync).
- Misroute:
  - 16'h0005 (dest 2) and 16'h000B (src==ID) → misroute_count=2;
  - rx_count unchanged, no flit_valid.
- Wrap: src0 16'hFFC3 (seq 2046) then 16'h0023 (seq 1) → no seq_error, rx_count=2.
- Saturation and clear:
  - force rx_count to all-ones via a long stream → holds at 16'hFFFF;
  - clear_stats coincident with a valid flit → rx_count=0 and flit_valid=1 that cycle;
  - reset mid-stream → first flit afterwards gives no seq_error.
